// File: rtl/alu.sv
// Combinational integer ALU for the execute stage: RV base ops plus the
// M-extension multiply/divide/remainder. A single shared adder supplies the
// add/sub results, the set-less-than comparisons and the branch flags.

package alu_pkg;
  typedef enum logic [4:0] {
    Add                   = 5'h00,
    ShiftLeftLogic        = 5'h01,
    SetLessThan           = 5'h02,
    SetLessThanUnsigned   = 5'h03,
    Xor                   = 5'h04,
    ShiftRightLogic       = 5'h05,
    Or                    = 5'h06,
    And                   = 5'h07,
    Mul                   = 5'h08,
    MulHigh               = 5'h09,
    MulHighSignedUnsigned = 5'h0A,
    MulHighUnsigned       = 5'h0B,
    Div                   = 5'h0C,
    DivUnsigned           = 5'h0D,
    Rem                   = 5'h0E,
    RemUnsigned           = 5'h0F,
    Sub                   = 5'h10,
    ShiftRightArithmetic  = 5'h15
  } alu_op_t;
endpackage

module alu
  import alu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [4:0]   alu_op,
  output logic [N-1:0] Y,
  output logic         zero,
  output logic         negative,
  output logic         carry_out,
  output logic         overflow
);

  localparam int SW = $clog2(N);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  alu_op_t op;
  assign op = alu_op_t'(alu_op);

  // ---------------- shared adder and flags ----------------
  // Sub and both compares reuse the adder as A + ~B + 1.
  logic         sub;
  logic [N-1:0] b_add;
  logic [N:0]   sum;
  logic [N-1:0] s;

  always_comb begin
    sub = (op == Sub) || (op == SetLessThan) || (op == SetLessThanUnsigned);
  end

  assign b_add     = sub ? ~B : B;
  assign sum       = {1'b0, A} + {1'b0, b_add} + {{N{1'b0}}, sub};
  assign s         = sum[N-1:0];
  assign zero      = ~|s;
  assign negative  = s[N-1];
  assign carry_out = sum[N];
  assign overflow  = ~(A[N-1] ^ B[N-1] ^ sub) & (A[N-1] ^ s[N-1]);

  // ---------------- shifter ----------------
  logic [SW-1:0] shamt;
  logic [N-1:0]  sll_res;
  logic [N-1:0]  srl_res;
  logic [N-1:0]  sra_res;

  assign shamt   = B[SW-1:0];
  assign sll_res = A << shamt;
  assign srl_res = A >> shamt;
  assign sra_res = $unsigned($signed(A) >>> shamt);

  // ---------------- multiplier ----------------
  // Operands are extended to 2N bits so one unsigned multiply per
  // signedness combination yields the exact 2N-bit product.
  logic [2*N-1:0] a_sx, a_zx, b_sx, b_zx;
  logic [2*N-1:0] p_ss, p_su, p_uu;

  assign a_sx = {{N{A[N-1]}}, A};
  assign a_zx = {{N{1'b0}}, A};
  assign b_sx = {{N{B[N-1]}}, B};
  assign b_zx = {{N{1'b0}}, B};
  assign p_ss = a_sx * b_sx;
  assign p_su = a_sx * b_zx;
  assign p_uu = a_zx * b_zx;

  // ---------------- divider ----------------
  // Signed division runs on magnitudes; the quotient takes the XOR of the
  // operand signs and the remainder the dividend's sign. A zero divisor is
  // replaced by one so the operators never produce X; the result mux then
  // substitutes the architectural divide-by-zero values.
  logic         a_neg, b_neg, b_is_zero, signed_ovf;
  logic [N-1:0] a_mag, b_mag;
  logic [N-1:0] div_u_den, div_s_den;
  logic [N-1:0] q_u, r_u, q_mag, r_mag, q_s, r_s;

  assign a_neg      = A[N-1];
  assign b_neg      = B[N-1];
  assign b_is_zero  = ~|B;
  assign signed_ovf = (A == MOST_NEG) && (B == ALL_ONES);
  assign a_mag      = a_neg ? (~A + ONE) : A;
  assign b_mag      = b_neg ? (~B + ONE) : B;
  assign div_u_den  = b_is_zero ? ONE : B;
  assign div_s_den  = b_is_zero ? ONE : b_mag;
  assign q_u        = A / div_u_den;
  assign r_u        = A % div_u_den;
  assign q_mag      = a_mag / div_s_den;
  assign r_mag      = a_mag % div_s_den;
  assign q_s        = (a_neg ^ b_neg) ? (~q_mag + ONE) : q_mag;
  assign r_s        = a_neg ? (~r_mag + ONE) : r_mag;

  // ---------------- result select ----------------
  // Pick the result for the requested op; unknown codes give zero.
  always_comb begin
    Y = '0;
    case (op)
      Add, Sub:              Y = s;
      SetLessThan:           Y = {{(N-1){1'b0}}, negative ^ overflow};
      SetLessThanUnsigned:   Y = {{(N-1){1'b0}}, ~carry_out};
      ShiftLeftLogic:        Y = sll_res;
      ShiftRightLogic:       Y = srl_res;
      ShiftRightArithmetic:  Y = sra_res;
      Xor:                   Y = A ^ B;
      Or:                    Y = A | B;
      And:                   Y = A & B;
      Mul:                   Y = p_uu[N-1:0];
      MulHigh:               Y = p_ss[2*N-1:N];
      MulHighSignedUnsigned: Y = p_su[2*N-1:N];
      MulHighUnsigned:       Y = p_uu[2*N-1:N];
      Div:                   Y = b_is_zero ? ALL_ONES : (signed_ovf ? A : q_s);
      DivUnsigned:           Y = b_is_zero ? ALL_ONES : q_u;
      Rem:                   Y = b_is_zero ? A : (signed_ovf ? '0 : r_s);
      RemUnsigned:           Y = b_is_zero ? A : r_u;
      default:               Y = '0;
    endcase
  end

  // Clock and reset exist only for interface uniformity; the low product
  // halves of the signed multiplies are not needed by any op.
  logic unused_ok;
  assign unused_ok = ^{clock, reset, p_ss[N-1:0], p_su[N-1:0]};

endmodule

// File: tb/tb_alu.sv
// Randomized scoreboard bench for the ALU at N=8. The driver applies
// operands on the rising edge and queues the expected response computed
// with plain integer arithmetic; the monitor checks on the falling edge.

module tb_alu;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [4:0]   op;
  logic [N-1:0] y;
  logic         z_f, n_f, c_f, v_f;
  logic         vld;

  typedef struct {
    logic [4:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] y;
    logic [3:0]   flags;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  alu #(.N(N)) dut (
    .clock     (clk),
    .reset     (rst_n),
    .A         (a),
    .B         (b),
    .alu_op    (op),
    .Y         (y),
    .zero      (z_f),
    .negative  (n_f),
    .carry_out (c_f),
    .overflow  (v_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RISC-V semantics in plain integer arithmetic.
  function automatic exp_t model(input logic [4:0] o, input logic [N-1:0] ai,
                                 input logic [N-1:0] bi);
    exp_t m;
    int ua, ub, sa, sb, s, ss, r, sh;
    bit is_sub;
    ua = int'(ai);
    ub = int'(bi);
    sa = int'($signed(ai));
    sb = int'($signed(bi));
    is_sub = (o == 5'h10) || (o == 5'h02) || (o == 5'h03);
    s  = is_sub ? (ua + 256 - ub) : (ua + ub);
    ss = is_sub ? (sa - sb) : (sa + sb);
    sh = ub % 8;
    case (o)
      5'h00: r = ua + ub;
      5'h10: r = ua - ub;
      5'h01: r = ua << sh;
      5'h02: r = (sa < sb) ? 1 : 0;
      5'h03: r = (ua < ub) ? 1 : 0;
      5'h04: r = ua ^ ub;
      5'h05: r = ua >> sh;
      5'h15: r = sa >>> sh;
      5'h06: r = ua | ub;
      5'h07: r = ua & ub;
      5'h08: r = ua * ub;
      5'h09: r = (sa * sb) >>> 8;
      5'h0A: r = (sa * ub) >>> 8;
      5'h0B: r = (ua * ub) >>> 8;
      5'h0C: r = (ub == 0) ? 255 : ((sa == -128 && sb == -1) ? 128 : sa / sb);
      5'h0D: r = (ub == 0) ? 255 : ua / ub;
      5'h0E: r = (ub == 0) ? ua : ((sa == -128 && sb == -1) ? 0 : sa % sb);
      5'h0F: r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    m.op = o;
    m.a  = ai;
    m.b  = bi;
    m.y  = 8'(r);
    // flags ordered {zero, negative, carry_out, overflow}
    m.flags[3] = ((s % 256) == 0);
    m.flags[2] = ((s % 256) >= 128);
    m.flags[1] = (s >= 256);
    m.flags[0] = (ss > 127) || (ss < -128);
    return m;
  endfunction

  task automatic issue(input logic [4:0] o, input logic [N-1:0] ai,
                       input logic [N-1:0] bi);
    @(posedge clk);
    op  = o;
    a   = ai;
    b   = bi;
    vld = 1'b1;
    exp_q.push_back(model(o, ai, bi));
  endtask

  // Directed vector whose result is fixed by hand; flags come from the model.
  task automatic issue_k(input logic [4:0] o, input logic [N-1:0] ai,
                         input logic [N-1:0] bi, input logic [N-1:0] yk);
    exp_t m;
    @(posedge clk);
    op  = o;
    a   = ai;
    b   = bi;
    vld = 1'b1;
    m   = model(o, ai, bi);
    m.y = yk;
    exp_q.push_back(m);
  endtask

  task automatic issue_kf(input logic [4:0] o, input logic [N-1:0] ai,
                          input logic [N-1:0] bi, input logic [N-1:0] yk,
                          input logic [3:0] fk);
    exp_t m;
    @(posedge clk);
    op  = o;
    a   = ai;
    b   = bi;
    vld = 1'b1;
    m.op = o;
    m.a = ai;
    m.b = bi;
    m.y = yk;
    m.flags = fk;
    exp_q.push_back(m);
  endtask

  // Monitor: pop the expected response and compare on the falling edge.
  always @(negedge clk) begin
    if (vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty op=%h A=%h B=%h Y=%h", op, a, b, y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if ($isunknown({y, z_f, n_f, c_f, v_f})) begin
          errors++;
          $display("FAIL x_check op=%h A=%h B=%h got Y=%h flags=%b", e.op, e.a, e.b,
                   y, {z_f, n_f, c_f, v_f});
        end
        checks++;
        if (y !== e.y) begin
          errors++;
          $display("FAIL result op=%h A=%h B=%h got Y=%h expected %h", e.op, e.a, e.b,
                   y, e.y);
        end
        checks++;
        if ({z_f, n_f, c_f, v_f} !== e.flags) begin
          errors++;
          $display("FAIL flags op=%h A=%h B=%h got zncv=%b expected %b", e.op, e.a,
                   e.b, {z_f, n_f, c_f, v_f}, e.flags);
        end
      end
    end
  end

  logic [4:0] ops[18] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                          5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F,
                          5'h10, 5'h15};
  logic [4:0] bad_ops[4] = '{5'h11, 5'h14, 5'h16, 5'h1F};

  initial begin
    rst_n = 1'b0;
    vld   = 1'b0;
    op    = 5'h00;
    a     = '0;
    b     = '0;

    // Outputs must be valid while reset is held.
    issue_kf(5'h00, 8'h7F, 8'h01, 8'h80, 4'b0101);
    issue_kf(5'h10, 8'h05, 8'h05, 8'h00, 4'b1010);
    @(posedge clk);
    rst_n = 1'b1;
    vld   = 1'b0;

    issue_kf(5'h00, 8'h7F, 8'h01, 8'h80, 4'b0101);
    issue_kf(5'h10, 8'h05, 8'h05, 8'h00, 4'b1010);
    issue_k(5'h03, 8'h01, 8'hFF, 8'h01);
    issue_k(5'h02, 8'h01, 8'hFF, 8'h00);
    issue_k(5'h15, 8'h80, 8'h0B, 8'hF0);
    issue_k(5'h05, 8'h80, 8'h0B, 8'h10);
    issue_k(5'h01, 8'h81, 8'h01, 8'h02);
    issue_k(5'h08, 8'hFF, 8'hFF, 8'h01);
    issue_k(5'h09, 8'hFF, 8'hFF, 8'h00);
    issue_k(5'h0A, 8'hFF, 8'hFF, 8'hFF);
    issue_k(5'h0B, 8'hFF, 8'hFF, 8'hFE);
    issue_k(5'h0C, 8'hF9, 8'h02, 8'hFD);
    issue_k(5'h0E, 8'hF9, 8'h02, 8'hFF);
    issue_k(5'h0C, 8'h5A, 8'h00, 8'hFF);
    issue_k(5'h0D, 8'h5A, 8'h00, 8'hFF);
    issue_k(5'h0E, 8'h5A, 8'h00, 8'h5A);
    issue_k(5'h0F, 8'hA5, 8'h00, 8'hA5);
    issue_k(5'h0C, 8'h80, 8'hFF, 8'h80);
    issue_k(5'h0E, 8'h80, 8'hFF, 8'h00);
    issue_k(5'h13, 8'h12, 8'h34, 8'h00);

    // Random sweep of every op, with zero divisors and the signed-overflow pair.
    for (int k = 0; k < 18; k++) begin
      for (int i = 0; i < 100; i++) begin
        logic [N-1:0] ra, rb;
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        if (i % 10 == 0) rb = 8'h00;
        if (i % 25 == 1) begin
          ra = 8'h80;
          rb = 8'hFF;
        end
        issue(ops[k], ra, rb);
      end
    end

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 5; i++) begin
        issue(bad_ops[k], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
    end

    @(posedge clk);
    vld = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
